// File: rtl/act_bwd_pkg.sv
// act_bwd_pkg: shared types and constants for the activation-derivative backward path.
//   q44_t        signed Q4.4 value (1.0 = 8'sh10)
//   FRAC_BITS    fractional bits of every Q4.4 value
//   LUT_DEPTH    derivative table entries, indexed by z[7:4]
//   state_e      backward-path FSM states
//   LUT_DEFAULT  sigmoid derivative x16, loaded at reset
//   sat_q44()    clamp a 16-bit signed value into the Q4.4 range
// Optional macro ACT_BWD_SAT_EN selects saturation instead of wrap in the users of this package.
package act_bwd_pkg;

   localparam int unsigned LUT_DEPTH = 16;
   localparam int unsigned FRAC_BITS = 4;

   typedef logic signed [7:0] q44_t;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StInterp,
      StScale,
      StOut
   } state_e;

   localparam q44_t LUT_DEFAULT [LUT_DEPTH] = '{
      8'sd4, 8'sd3, 8'sd2, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0,
      8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd2, 8'sd3
   };

   function automatic q44_t sat_q44(input logic signed [15:0] v);
      if (v > 16'sd127) begin
         return 8'sh7F;
      end else if (v < -16'sd128) begin
         return 8'sh80;
      end else begin
         return q44_t'(v);
      end
   endfunction

endpackage

// File: rtl/act_bwd_interp.sv
// act_bwd_interp: combinational linear interpolation between two derivative table entries.
// Uses the same arithmetic rules as the forward activation interpolator.
//   base   in  8  signed Q4.4 entry at the segment start
//   next_v in  8  signed Q4.4 entry at the segment end
//   rem    in  4  position inside the segment (z[3:0], unsigned)
//   d      out 8  interpolated derivative, signed Q4.4
// Macro ACT_BWD_SAT_EN: saturate d to [-128, 127]; otherwise keep the low 8 bits.
module act_bwd_interp
   import act_bwd_pkg::*;
(
   input  logic [7:0] base,
   input  logic [7:0] next_v,
   input  logic [3:0] rem,
   output logic [7:0] d
);

   logic signed [12:0] base_x;
   logic signed [12:0] next_x;
   logic signed [12:0] rem_x;
   logic signed [12:0] prod;
   logic signed [12:0] sum;

   always_comb begin
      base_x = $signed({{5{base[7]}}, base});
      next_x = $signed({{5{next_v[7]}}, next_v});
      rem_x  = $signed({9'b0, rem});
      // |next - base| <= 255 and rem <= 15, so the product fits 13 bits.
      prod   = (next_x - base_x) * rem_x;
      sum    = base_x + (prod >>> FRAC_BITS);
`ifdef ACT_BWD_SAT_EN
      d      = sat_q44($signed({{3{sum[12]}}, sum}));
`else
      d      = q44_t'(sum);
`endif
   end

endmodule

// File: rtl/act_deriv_backprop.sv
// act_deriv_backprop: computes delta = err * f'(z) for the xor network backward pass, with f'
// taken from a run-time writable 16-entry derivative table and linearly interpolated.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   z_value/err handshake (signed Q4.4 each)
//   out_valid/out_ready delta handshake (signed Q4.4)
//   lut_we/lut_waddr/lut_wdata/lut_wready  table write port, accepted only while idle
// Macro ACT_BWD_SAT_EN: saturate d and delta to [-128, 127]; otherwise wrap to 8 bits.
module act_deriv_backprop
   import act_bwd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] z_value,
   input  logic [7:0] err,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] delta,
   input  logic       lut_we,
   input  logic [3:0] lut_waddr,
   input  logic [7:0] lut_wdata,
   output logic       lut_wready
);

   state_e state_q;
   q44_t   z_q;
   q44_t   err_q;
   q44_t   base_q;
   q44_t   next_q;
   q44_t   d_q;
   q44_t   delta_q;
   q44_t   lut_q [LUT_DEPTH];

   logic [3:0] addr;
   logic [3:0] addr_p1;
   q44_t       lut_base;
   q44_t       lut_next;
   logic [7:0] d_comb;
   q44_t       p_comb;
   logic signed [15:0] prod;

   assign in_ready   = (state_q == StIdle);
   assign lut_wready = (state_q == StIdle);
   assign out_valid  = (state_q == StOut);
   assign delta      = delta_q;

   // Table lookup. Address F wraps to 0 (continuous across zero); the top positive segment
   // has no successor, so it is flat.
   assign addr     = z_q[7:4];
   assign addr_p1  = addr + 4'd1;
   assign lut_base = lut_q[addr];
   assign lut_next = (addr == 4'h7) ? lut_base : lut_q[addr_p1];

   act_bwd_interp u_interp (
      .base   (base_q),
      .next_v (next_q),
      .rem    (z_q[3:0]),
      .d      (d_comb)
   );

   // Scale: both operands are 8-bit signed, so the true product fits 16 bits.
   always_comb begin
      prod = $signed({{8{err_q[7]}}, err_q}) * $signed({{8{d_q[7]}}, d_q});
`ifdef ACT_BWD_SAT_EN
      p_comb = sat_q44(prod >>> FRAC_BITS);
`else
      p_comb = q44_t'(prod >>> FRAC_BITS);
`endif
   end

   // Derivative table; writes only land while idle, so a transaction in flight never sees
   // its table change underneath it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            lut_q[i] <= LUT_DEFAULT[i];
         end
      end else if (lut_we && lut_wready) begin
         lut_q[lut_waddr] <= lut_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         z_q     <= '0;
         err_q   <= '0;
         base_q  <= '0;
         next_q  <= '0;
         d_q     <= '0;
         delta_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  z_q     <= z_value;
                  err_q   <= err;
                  state_q <= StLookup;
               end
            end
            StLookup: begin
               base_q  <= lut_base;
               next_q  <= lut_next;
               state_q <= StInterp;
            end
            StInterp: begin
               d_q     <= d_comb;
               state_q <= StScale;
            end
            StScale: begin
               delta_q <= p_comb;
               state_q <= StOut;
            end
            StOut: begin
               if (out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
